// File: rtl/test_pattern_sequencer_pkg.sv
// Shared test-pattern constants: one-hot pattern encodings, their cyclic
// order, and the step requests the pattern sequencer understands.
package test_pattern_sequencer_pkg;

  // Pattern select width and frame counter width
  localparam int IMG_W    = 4;
  localparam int FRAMES_W = 8;

  typedef logic [IMG_W-1:0] image_t;

  // One-hot pattern encodings, shared with the image generator
  localparam image_t IMG_RECT = 4'b0001;
  localparam image_t IMG_VBAR = 4'b0010;
  localparam image_t IMG_HBAR = 4'b0100;
  localparam image_t IMG_GRAY = 4'b1000;

  // Button indices inside the per-button vectors
  localparam int BTN_NEXT = 0;
  localparam int BTN_PREV = 1;
  localparam int NUM_BTNS = 2;

  // Manual step resolved from the pending request flags
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_NEXT = 2'd1,
    STEP_PREV = 2'd2
  } step_t;

  // True only for the four legal pattern encodings
  function automatic logic image_is_onehot(input image_t img);
    case (img)
      IMG_RECT, IMG_VBAR, IMG_HBAR, IMG_GRAY: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // Forward order: rectangle -> V bars -> H bars -> gray scale -> rectangle
  function automatic image_t image_succ(input image_t img);
    case (img)
      IMG_RECT: return IMG_VBAR;
      IMG_VBAR: return IMG_HBAR;
      IMG_HBAR: return IMG_GRAY;
      default:  return IMG_RECT;
    endcase
  endfunction

  // Reverse order: rectangle -> gray scale -> H bars -> V bars -> rectangle
  function automatic image_t image_pred(input image_t img);
    case (img)
      IMG_RECT: return IMG_GRAY;
      IMG_GRAY: return IMG_HBAR;
      IMG_HBAR: return IMG_VBAR;
      default:  return IMG_RECT;
    endcase
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-FF synchronizer followed by a stability counter.
// The debounced level only follows the synchronized input after it has held
// a new value for DEBOUNCE_CYCLES consecutive clocks; a one-cycle pulse on
// rise marks each accepted low-to-high transition.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic Clock,
  input  logic Reset,
  input  logic btn,
  output logic rise
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic             stable_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             rise_reg;

  // Synchronize the raw button, then accept a level change only once it has
  // been seen continuously for the full debounce window
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync_reg   <= '0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
      rise_reg   <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], btn};
      rise_reg <= 1'b0;
      if (sync_reg[1] == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_MAX) begin
        stable_reg <= sync_reg[1];
        cnt_reg    <= '0;
        rise_reg   <= sync_reg[1];
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/test_pattern_sequencer.sv
// test_pattern_sequencer: selects the active test pattern, either cycling
// automatically every DWELL_FRAMES frames or stepping on Next/Prev buttons.
// All pattern changes are applied on the edge that samples FrameTick so the
// image generator only ever switches between frames.
// Build option: define PATTERN_SEQ_DEBOUNCE_EN to debounce the buttons;
// otherwise each button gets a 2-FF synchronizer and rising-edge detector.
module test_pattern_sequencer
  import test_pattern_sequencer_pkg::*;
#(
  parameter int DWELL_FRAMES    = 150,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                FrameTick,
  input  logic                Auto,
  input  logic                Freeze,
  input  logic                BtnNext,
  input  logic                BtnPrev,
  output logic [IMG_W-1:0]    ImageState,
  output logic [FRAMES_W-1:0] FramesLeft,
  output logic                StateChanged
);

  localparam logic [FRAMES_W-1:0] DWELL_RELOAD = FRAMES_W'(DWELL_FRAMES);

`ifndef PATTERN_SEQ_DEBOUNCE_EN
  // Debounce length only matters when the debouncer is built in
  localparam int debounce_cycles_unused = DEBOUNCE_CYCLES;
`endif

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_rise;

  image_t              image_reg;
  image_t              image_next;
  logic [FRAMES_W-1:0] frames_reg;
  logic [FRAMES_W-1:0] frames_next;
  logic                changed_reg;
  logic                pend_next_reg;
  logic                pend_prev_reg;
  logic                consume;
  step_t               manual_step;

  assign btn_raw = {BtnPrev, BtnNext};

  // Per-button front end: turns a raw asynchronous level into a single-cycle
  // qualified press pulse in the Clock domain
  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
`ifdef PATTERN_SEQ_DEBOUNCE_EN
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .Clock(Clock),
      .Reset(Reset),
      .btn  (btn_raw[gi]),
      .rise (btn_rise[gi])
    );
`else
    logic [1:0] sync_reg;
    logic       last_reg;

    // Two-stage synchronizer plus a delayed copy for edge detection
    always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
        sync_reg <= '0;
        last_reg <= 1'b0;
      end else begin
        sync_reg <= {sync_reg[0], btn_raw[gi]};
        last_reg <= sync_reg[1];
      end
    end

    assign btn_rise[gi] = sync_reg[1] & ~last_reg;
`endif
  end

  // A FrameTick outside Freeze consumes whatever requests are pending
  assign consume = FrameTick & ~Freeze;

  // Resolve pending flags to a single manual step; both pending cancels out
  always_comb begin
    manual_step = STEP_NONE;
    if (pend_next_reg && !pend_prev_reg) begin
      manual_step = STEP_NEXT;
    end else if (pend_prev_reg && !pend_next_reg) begin
      manual_step = STEP_PREV;
    end
  end

  // Pending request flags: repeated presses within a frame collapse into one
  // flag; a press landing on the consuming tick survives into the next frame
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pend_next_reg <= 1'b0;
      pend_prev_reg <= 1'b0;
    end else begin
      pend_next_reg <= (pend_next_reg & ~consume) | btn_rise[BTN_NEXT];
      pend_prev_reg <= (pend_prev_reg & ~consume) | btn_rise[BTN_PREV];
    end
  end

  // Next pattern and dwell count: manual step wins over auto advance, manual
  // mode parks the counter at the full dwell so Auto 0->1 starts fresh
  always_comb begin
    image_next  = image_reg;
    frames_next = frames_reg;
    if (!Auto) begin
      frames_next = DWELL_RELOAD;
    end
    if (FrameTick) begin
      if (!image_is_onehot(image_reg)) begin
        // Corrupted select is not a pattern worth holding, even when frozen
        image_next = IMG_RECT;
      end else if (!Freeze) begin
        case (manual_step)
          STEP_NEXT: begin
            image_next  = image_succ(image_reg);
            frames_next = DWELL_RELOAD;
          end
          STEP_PREV: begin
            image_next  = image_pred(image_reg);
            frames_next = DWELL_RELOAD;
          end
          default: begin
            if (Auto) begin
              if (frames_reg <= FRAMES_W'(1)) begin
                image_next  = image_succ(image_reg);
                frames_next = DWELL_RELOAD;
              end else begin
                frames_next = frames_reg - FRAMES_W'(1);
              end
            end
          end
        endcase
      end
    end
  end

  // Pattern, dwell counter and change strobe registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      image_reg   <= IMG_RECT;
      frames_reg  <= DWELL_RELOAD;
      changed_reg <= 1'b0;
    end else begin
      image_reg   <= image_next;
      frames_reg  <= frames_next;
      changed_reg <= (image_next != image_reg);
    end
  end

  assign ImageState   = image_reg;
  assign FramesLeft   = frames_reg;
  assign StateChanged = changed_reg;

endmodule

// File: tb/tb_test_pattern_sequencer.sv
// Self-checking bench for test_pattern_sequencer (DWELL_FRAMES=3,
// DEBOUNCE_CYCLES=16). A pattern-index model tracks the expected outputs every
// cycle; directed scenarios add literal expectations after each FrameTick.
module tb_test_pattern_sequencer;

  localparam int DWELL = 3;
  localparam int DEB   = 16;
`ifdef PATTERN_SEQ_DEBOUNCE_EN
  localparam int LAT      = 3 + DEB;
  localparam int MIN_HOLD = DEB;
  localparam int HOLD     = 20;
  localparam int GAP      = 45;
`else
  localparam int LAT      = 3;
  localparam int MIN_HOLD = 1;
  localparam int HOLD     = 2;
  localparam int GAP      = 8;
`endif

  logic       Clock     = 1'b0;
  logic       Reset     = 1'b0;
  logic       FrameTick = 1'b0;
  logic       Auto      = 1'b0;
  logic       Freeze    = 1'b0;
  logic       BtnNext   = 1'b0;
  logic       BtnPrev   = 1'b0;
  logic [3:0] ImageState;
  logic [7:0] FramesLeft;
  logic       StateChanged;

  int tests    = 0;
  int fails    = 0;
  int cyc      = 0;
  int sc_count = 0;

  // Model state: pattern as an index 0..3 in forward order
  int m_idx = 0;
  int m_fl  = DWELL;
  bit m_pn  = 1'b0;
  bit m_pp  = 1'b0;
  bit m_sc  = 1'b0;
  int arr_n[$];
  int arr_p[$];

  always #5 Clock = ~Clock;

  test_pattern_sequencer #(
    .DWELL_FRAMES   (DWELL),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .FrameTick   (FrameTick),
    .Auto        (Auto),
    .Freeze      (Freeze),
    .BtnNext     (BtnNext),
    .BtnPrev     (BtnPrev),
    .ImageState  (ImageState),
    .FramesLeft  (FramesLeft),
    .StateChanged(StateChanged)
  );

  function automatic logic [3:0] pat(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  // Per-cycle model update and comparison, 1 time unit after each edge
  initial begin : compare
    logic s_rst, s_tick, s_auto, s_frz;
    int   old_idx;
    forever begin
      @(posedge Clock);
      s_rst  = Reset;
      s_tick = FrameTick;
      s_auto = Auto;
      s_frz  = Freeze;
      #1;
      cyc++;
      if (!s_rst) begin
        m_idx = 0; m_fl = DWELL; m_pn = 0; m_pp = 0; m_sc = 0;
        arr_n.delete(); arr_p.delete();
      end else begin
        old_idx = m_idx;
        if (!s_auto) m_fl = DWELL;
        if (s_tick && !s_frz) begin
          if (m_pn != m_pp) begin
            m_idx = m_pn ? (m_idx + 1) % 4 : (m_idx + 3) % 4;
            m_fl  = DWELL;
          end else if (s_auto) begin
            if (m_fl == 1) begin
              m_idx = (m_idx + 1) % 4;
              m_fl  = DWELL;
            end else begin
              m_fl = m_fl - 1;
            end
          end
          m_pn = 0;
          m_pp = 0;
        end
        while (arr_n.size() > 0 && arr_n[0] <= cyc) begin
          void'(arr_n.pop_front());
          m_pn = 1;
        end
        while (arr_p.size() > 0 && arr_p[0] <= cyc) begin
          void'(arr_p.pop_front());
          m_pp = 1;
        end
        m_sc = (m_idx != old_idx);
      end
      check("model_img", ImageState, pat(m_idx));
      check("model_frames", FramesLeft, m_fl);
      check("model_changed", StateChanged, m_sc);
      if (StateChanged === 1'b1) sc_count++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic frame_tick(input string tag);
    @(negedge Clock);
    FrameTick = 1'b1;
    @(negedge Clock);
    FrameTick = 1'b0;
    $display("[TB] %s tick: ImageState=%b FramesLeft=%0d StateChanged=%b",
             tag, ImageState, FramesLeft, StateChanged);
  endtask

  task automatic press(input bit nxt, input int hold);
    @(negedge Clock);
    if (hold >= MIN_HOLD) begin
      if (nxt) arr_n.push_back(cyc + LAT);
      else     arr_p.push_back(cyc + LAT);
    end
    if (nxt) BtnNext = 1'b1;
    else     BtnPrev = 1'b1;
    repeat (hold) @(negedge Clock);
    BtnNext = 1'b0;
    BtnPrev = 1'b0;
    idle(GAP);
  endtask

  task automatic do_reset();
    Auto   = 1'b0;
    Freeze = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    idle(2);
    Reset = 1'b1;
  endtask

  // Watchdog: bounded run time
  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    logic [3:0] exp_img[7];
    logic [7:0] exp_fl[7];
    exp_img = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100};
    exp_fl  = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2};

    // Reset state
    idle(3);
    check("reset_img", ImageState, 4'b0001);
    check("reset_frames", FramesLeft, 8'd3);
    check("reset_changed", StateChanged, 1'b0);
    Reset = 1'b1;
    idle(2);

    // Auto cycling, 7 frames
    Auto     = 1'b1;
    sc_count = 0;
    for (int k = 0; k < 7; k++) begin
      idle(3);
      frame_tick("auto");
      check("auto_img", ImageState, exp_img[k]);
      check("auto_frames", FramesLeft, exp_fl[k]);
    end
    check("auto_pulses", sc_count, 2);

    // Manual next
    do_reset();
    idle(2);
    press(1'b1, HOLD);
    check("manual_before", ImageState, 4'b0001);
    frame_tick("manual next");
    check("manual_img", ImageState, 4'b0010);
    check("manual_frames", FramesLeft, 8'd3);
    check("manual_changed", StateChanged, 1'b1);

    // Next and prev in the same frame cancel
    press(1'b1, HOLD);
    press(1'b0, HOLD);
    frame_tick("both");
    check("both_img", ImageState, 4'b0010);
    check("both_changed", StateChanged, 1'b0);

    // Freeze holds a prev request across two frames
    do_reset();
    Freeze = 1'b1;
    press(1'b0, HOLD);
    frame_tick("frozen");
    check("frozen_img1", ImageState, 4'b0001);
    frame_tick("frozen");
    check("frozen_img2", ImageState, 4'b0001);
    Freeze = 1'b0;
    idle(2);
    frame_tick("unfrozen");
    check("unfrozen_img", ImageState, 4'b1000);
    check("unfrozen_changed", StateChanged, 1'b1);

`ifdef PATTERN_SEQ_DEBOUNCE_EN
    // Short glitches never qualify; a long press gives exactly one step
    repeat (3) press(1'b1, 5);
    frame_tick("glitch");
    check("glitch_img", ImageState, 4'b1000);
    press(1'b1, HOLD);
    frame_tick("debounced");
    check("debounced_img", ImageState, 4'b0001);
`else
    // Request lands on the same edge as FrameTick: it waits one frame
    @(negedge Clock);
    arr_n.push_back(cyc + LAT);
    BtnNext = 1'b1;
    @(negedge Clock);
    BtnNext = 1'b0;
    @(negedge Clock);
    FrameTick = 1'b1;
    @(negedge Clock);
    FrameTick = 1'b0;
    $display("[TB] late press tick: ImageState=%b", ImageState);
    check("late_press_img", ImageState, 4'b1000);
    idle(3);
    frame_tick("late press");
    check("late_press_next", ImageState, 4'b0001);
`endif

    // Several presses in one frame coalesce into one step
    repeat (3) press(1'b1, HOLD);
    frame_tick("coalesce");
    check("coalesce_img", ImageState, 4'b0010);

    // Reset with H bars showing and a request pending
    press(1'b1, HOLD);
    frame_tick("to hbars");
    check("pre_reset_img", ImageState, 4'b0100);
    press(1'b1, HOLD);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("async_reset_img", ImageState, 4'b0001);
    check("async_reset_frames", FramesLeft, 8'd3);
    check("async_reset_changed", StateChanged, 1'b0);
    idle(2);
    Reset = 1'b1;
    Auto  = 1'b1;
    idle(2);
    frame_tick("post reset");
    check("post_reset_img1", ImageState, 4'b0001);
    frame_tick("post reset");
    check("post_reset_img2", ImageState, 4'b0001);
    frame_tick("post reset");
    check("post_reset_img3", ImageState, 4'b0010);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/test_pattern_sequencer.md
TEST_PATTERN_SEQUENCER -- requirements
Module: test_pattern_sequencer

Interface
REQ-001 SHALL have parameter DWELL_FRAMES, default 150, frames per pattern in auto mode (legal 1..255).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 65536, Clock cycles a button level must be stable (legal 2..2^20-1).
REQ-003 SHALL have port Clock  input  1  pixel clock; all logic on rising edge.
REQ-004 SHALL have port Reset  input  1  reset Reset, asynchronous, active-low.
REQ-005 SHALL have port FrameTick  input  1  one-cycle pulse at end of frame from timing generator.
REQ-006 SHALL have port Auto  input  1  1 = auto-cycle patterns, 0 = manual only.
REQ-007 SHALL have port Freeze  input  1  1 = hold current pattern, no changes applied.
REQ-008 SHALL have port BtnNext  input  1  raw asynchronous push-button, active-high.
REQ-009 SHALL have port BtnPrev  input  1  raw asynchronous push-button, active-high.
REQ-010 SHALL have port ImageState  output  4  one-hot pattern select: 0001 rectangle, 0010 V bars, 0100 H bars, 1000 gray scale.
REQ-011 SHALL have port FramesLeft  output  8  frames remaining before next auto advance.
REQ-012 SHALL have port StateChanged  output  1  one-cycle pulse coincident with each ImageState update.

Function
REQ-013 SHALL change ImageState only in the cycle after a sampled FrameTick, so pattern switches are frame-aligned.
REQ-014 SHALL advance in order rectangle -> V bars -> H bars -> gray scale -> rectangle; "prev" SHALL step the reverse order.
REQ-015 SHALL force any non-one-hot ImageState to 0001 on the next FrameTick.
REQ-016 SHALL, in auto mode with Freeze=0, decrement FramesLeft on each FrameTick; on FrameTick with FramesLeft==1, advance ImageState and reload FramesLeft=DWELL_FRAMES.
REQ-017 SHALL, in manual mode, hold FramesLeft at DWELL_FRAMES and never auto-advance.
REQ-018 SHALL convert each qualified button press (synchronized rising edge) into a pending request flag, held until consumed on a FrameTick.
REQ-019 SHALL, on FrameTick with a pending request and Freeze=0, apply it (one step), clear it, reload FramesLeft=DWELL_FRAMES; manual request SHALL take priority over auto advance in that frame.
REQ-020 SHALL, if next and prev are both pending at a FrameTick, discard both and apply no manual step.
REQ-021 SHALL coalesce multiple presses of the same button within one frame into a single step.
REQ-022 SHALL, while Freeze=1, apply no change, hold FramesLeft, and retain pending requests until Freeze=0.
REQ-023 SHALL, on Auto 0->1, start with FramesLeft=DWELL_FRAMES.
REQ-024 SHALL assert StateChanged only when ImageState value actually changes.

Reset
REQ-025 SHALL on Reset low immediately set ImageState=0001, FramesLeft=DWELL_FRAMES, StateChanged=0, pending flags=0, synchronizers and debounce counters=0.
REQ-026 SHALL, on reset mid-frame, discard pending requests; first advance occurs DWELL_FRAMES FrameTicks after release in auto mode.

Configuration
REQ-027 SHALL, with macro PATTERN_SEQ_DEBOUNCE_EN defined, pass each button through 2-FF synchronizer plus debouncer; edge qualified only after DEBOUNCE_CYCLES stable cycles.
REQ-028 SHALL, without PATTERN_SEQ_DEBOUNCE_EN, use 2-FF synchronizer plus rising-edge detect only (request latched 3 cycles after button rise).

Structure
REQ-029 SHALL take one-hot ImageState encodings and their successor/predecessor order from the shared test-pattern constants package used by the image generator.
REQ-030 SHALL instantiate sub-module button_debouncer (one per button) when PATTERN_SEQ_DEBOUNCE_EN is defined.

Verification
REQ-031 SHALL test: DWELL_FRAMES=3, Auto=1, 7 FrameTicks -> ImageState 0001,0001,0001->0010 after 3rd, 0100 after 6th; StateChanged 2 pulses.
REQ-032 SHALL test: Auto=0, BtnNext pulse mid-frame -> ImageState 0001->0010 one cycle after next FrameTick, FramesLeft=3.
REQ-033 SHALL test: BtnNext and BtnPrev both pressed in same frame -> no change at FrameTick, StateChanged=0.
REQ-034 SHALL test: Freeze=1, BtnPrev pressed, 2 FrameTicks -> unchanged; Freeze=0, next FrameTick -> 0001->1000.
REQ-035 SHALL test: debounce on, DEBOUNCE_CYCLES=16, button glitches of 5 cycles -> no request; 20-cycle press -> one request.
REQ-036 SHALL test: Reset asserted while ImageState=0100 with request pending -> immediate 0001, FramesLeft=DWELL_FRAMES, no step after release.
